// File: rtl/seg7_scan_display.sv
// Multi-digit 7-segment driver: sequential binary-to-BCD (shift-add-3), sign and
// leading-zero formatting, and time-multiplexed active-low digit scanning.
module seg7_scan_display #(
  parameter int N_DIGITS = 4,
  parameter int WIDTH    = 10,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  input  logic                neg,
  input  logic                blank_lz,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [6:0]          SEG,
  output logic [N_DIGITS-1:0] AN
);

  localparam int BW = 4 * N_DIGITS + 4;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);

  localparam logic [6:0]    MINUS   = 7'b0111111;
  localparam logic [6:0]    BLANK   = 7'b1111111;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIM_POS = pow10(N_DIGITS);
  localparam logic [63:0] LIM_NEG = pow10(N_DIGITS - 1);

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'b1000000;
      4'd1: seg_of = 7'b1111001;
      4'd2: seg_of = 7'b0100100;
      4'd3: seg_of = 7'b0110000;
      4'd4: seg_of = 7'b0011001;
      4'd5: seg_of = 7'b0010010;
      4'd6: seg_of = 7'b0000010;
      4'd7: seg_of = 7'b1111000;
      4'd8: seg_of = 7'b0000000;
      4'd9: seg_of = 7'b0011000;
      default: seg_of = BLANK;
    endcase
  endfunction

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < N_DIGITS + 1; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic [WIDTH-1:0]           shreg;
  logic [BW-1:0]              bcd;
  logic [BW-1:0]              bcd_nx;
  logic                       neg_l;
  logic                       bl_l;
  logic                       zero_l;
  logic                       ovf_l;
  logic                       ovf_start;
  logic [63:0]                value_w;
  logic [N_DIGITS-1:0][6:0]   codes;
  logic [N_DIGITS-1:0][6:0]   codes_nx;
  int                         lz_top;
  logic                       show_minus;
  logic [PW-1:0]              pre;
  logic [IW-1:0]              idx;
  logic                       scan_on;

  assign value_w   = 64'(value);
  assign ovf_start = neg ? ((value != '0) && (value_w >= LIM_NEG)) : (value_w >= LIM_POS);

  // One double-dabble step; the spare top nibble guarantees the dropped MSB is zero.
  assign bcd_nx = (add3(bcd) << 1) | BW'(shreg[WIDTH-1]);

  // Display codes are built from the post-shift BCD so they land with the final shift.
  always_comb begin
    lz_top     = 0;
    show_minus = neg_l && !zero_l;
    codes_nx   = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (bcd_nx[4*i +: 4] != 4'd0) lz_top = i;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (ovf_l)
        codes_nx[i] = MINUS;
      else if (bl_l) begin
        if (i <= lz_top)                       codes_nx[i] = seg_of(bcd_nx[4*i +: 4]);
        else if (show_minus && i == lz_top + 1) codes_nx[i] = MINUS;
        else                                   codes_nx[i] = BLANK;
      end else begin
        if (show_minus && i == N_DIGITS - 1)   codes_nx[i] = MINUS;
        else                                   codes_nx[i] = seg_of(bcd_nx[4*i +: 4]);
      end
    end
  end

  // Control FSM: CONV->LOAD edge commits codes and raises done for the LOAD cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      codes    <= {N_DIGITS{BLANK}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= CONV;
          busy  <= 1'b1;
        end
        CONV: if (cnt == CNT_MAX) begin
          state    <= LOAD;
          codes    <= codes_nx;
          done     <= 1'b1;
          overflow <= ovf_l;
        end
        LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Conversion datapath: operands captured at start, shifted during CONV.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      cnt    <= '0;
      shreg  <= value;
      bcd    <= '0;
      neg_l  <= neg;
      bl_l   <= blank_lz;
      zero_l <= (value == '0);
      ovf_l  <= ovf_start;
    end else if (state == CONV) begin
      cnt   <= cnt + 1'b1;
      shreg <= shreg << 1;
      bcd   <= bcd_nx;
    end
  end

  // Free-running scan: prescaler and digit index, independent of the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre     <= '0;
      idx     <= '0;
      scan_on <= 1'b0;
    end else begin
      scan_on <= 1'b1;
      if (pre == PRE_MAX) begin
        pre <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  always_comb begin
    AN = '1;
    if (scan_on) AN[idx] = 1'b0;
    SEG = codes[idx];
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized scoreboard bench for seg7_scan_display: expected displays are queued at
// start and compared by a monitor on done, with the scanned SEG/AN checked every cycle.
module tb_seg7_scan_display;

  localparam int ND = 4;
  localparam int W  = 10;
  localparam int SD = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  value = '0;
  logic          neg = 1'b0;
  logic          blank_lz = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [6:0]    SEG;
  logic [ND-1:0] AN;

  seg7_scan_display #(.N_DIGITS(ND), .WIDTH(W), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .neg(neg),
    .blank_lz(blank_lz), .busy(busy), .done(done), .overflow(overflow),
    .SEG(SEG), .AN(AN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] codes;
    logic        ovf;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          k = 0;
  logic        armed = 1'b0;
  logic        rst_hit = 1'b0;
  logic [27:0] disp_exp = '1;
  logic        ovf_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0011000;
    endcase
  endfunction

  // Reference: decimal digits by division, then apply sign/blanking/overflow rules.
  function automatic void model(input int v, input bit n, input bit bl,
                                output logic [27:0] c, output logic o);
    int d[4];
    int r;
    int top;
    bit minus;
    logic [6:0] s;
    r = v;
    for (int i = 0; i < 4; i++) begin
      d[i] = r % 10;
      r = r / 10;
    end
    o = (v >= 10000) || (n && v != 0 && v >= 1000);
    minus = n && (v != 0);
    top = 0;
    for (int i = 0; i < 4; i++) if (d[i] != 0) top = i;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      if (o) s = 7'b0111111;
      else if (bl) begin
        if (i <= top) s = seg_of(d[i]);
        else if (minus && i == top + 1) s = 7'b0111111;
        else s = 7'b1111111;
      end else begin
        if (minus && i == 3) s = 7'b0111111;
        else s = seg_of(d[i]);
      end
      c[i*7 +: 7] = s;
    end
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_hit <= reset;
    if (reset) begin
      k <= 0;
      armed <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  // Monitor: commits expected display on done, then checks scan outputs every cycle.
  always @(negedge clk) begin
    if (armed) begin
      exp_t e;
      int ix;
      logic [3:0] an_e;
      if (rst_hit) begin
        disp_exp = '1;
        ovf_exp = 1'b0;
      end
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("latency", 32'(cyc - e.t), 32'(W));
          chk("busy_in_load", 32'(busy), 32'd1);
          disp_exp = e.codes;
          ovf_exp = e.ovf;
        end
      end
      ix = (k / SD) % ND;
      an_e = (k == 0) ? 4'hF : ~(4'b0001 << ix);
      chk("AN", 32'(AN), 32'(an_e));
      chk("SEG", 32'(SEG), 32'(disp_exp[ix*7 +: 7]));
      chk("overflow", 32'(overflow), 32'(ovf_exp));
    end
  end

  task automatic do_conv(input int v, input bit n, input bit bl, input int gap);
    exp_t e;
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    start = 1'b1;
    value = W'(v);
    neg = n;
    blank_lz = bl;
    model(v, n, bl, e.codes, e.ovf);
    e.t = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    value = W'($urandom);
    neg = 1'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    g = 0;
    while (done !== 1'b1 && g < W + 5) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("busy_after_load", 32'(busy), 32'd0);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(SEG), 32'h7F);
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_conv(7, 1'b0, 1'b1, 12);
    do_conv(45, 1'b1, 1'b1, 12);
    do_conv(45, 1'b1, 1'b0, 12);
    do_conv(1000, 1'b1, 1'b1, 12);
    do_conv(999, 1'b0, 1'b1, 12);
    do_conv(0, 1'b1, 1'b0, 0);
    do_conv(1023, 1'b0, 1'b0, 0);

    // Start pulsed while busy must be dropped: exactly one done follows.
    start = 1'b1; value = W'(0); neg = 1'b1; blank_lz = 1'b1;
    begin
      exp_t e;
      model(0, 1'b1, 1'b1, e.codes, e.ovf);
      e.t = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; value = W'(5); neg = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 14) @(negedge clk);
    chk("busy_drop_only_one", 32'(q.size()), 32'd0);

    for (int i = 0; i < 16; i++)
      do_conv(int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), (i % 3 == 0) ? 0 : 12);

    // Reset in the middle of a conversion: no done, display blanks.
    start = 1'b1; value = W'(123); neg = 1'b0; blank_lz = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_seg", 32'(SEG), 32'h7F);
    chk("rst_mid_done", 32'(done), 32'd0);
    repeat (W + 10) @(negedge clk);

    do_conv(86, 1'b1, 1'b1, 12);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
